// File: rtl/mfhwt_row_writer.sv
// MFHWT line-buffer write sequencer: steers raster rows into four row FIFOs
// (row mod 4) and flags completed 4-row bands and frame end.
module mfhwt_row_writer #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int DW    = 16
) (
  input  logic          iClk,
  input  logic          iRst,
  input  logic          iStart,
  input  logic          iValid,
  input  logic [DW-1:0] iData,
  output logic          oReady,
  input  logic [3:0]    iFull,
  output logic [3:0]    oWrreq,
  output logic [DW-1:0] oData,
  output logic          oBandDone,
  output logic          oFrameDone,
  output logic          oBusy
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [1:0]    slot_q, slot_d;
  logic [RW-1:0] row_q, row_d;
  logic          band_q, band_d;
  logic          frame_q, frame_d;
  logic          busy_q, busy_d;

  logic          ready;
  logic          accept;

  // Only the FIFO of the current slot can stall the stream.
  assign ready  = (state_q == S_WRITE) & ~iFull[slot_q];
  assign accept = iValid & ready;

  assign oReady     = ready;
  assign oWrreq     = accept ? (4'b0001 << slot_q) : 4'b0000;
  assign oData      = iData;
  assign oBandDone  = band_q;
  assign oFrameDone = frame_q;
  assign oBusy      = busy_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    slot_d  = slot_q;
    row_d   = row_q;
    band_d  = 1'b0;
    frame_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d = S_WRITE;
          col_d   = '0;
          slot_d  = 2'd0;
          row_d   = '0;
        end
      end
      S_WRITE: begin
        if (accept) begin
          if (col_q == COL_LAST) begin
            col_d  = '0;
            slot_d = slot_q + 2'd1;
            band_d = (slot_q == 2'd3);
            if (row_q == ROW_LAST) begin
              state_d = S_DONE;
              frame_d = 1'b1;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      slot_q  <= 2'd0;
      row_q   <= '0;
      band_q  <= 1'b0;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      slot_q  <= slot_d;
      row_q   <= row_d;
      band_q  <= band_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_mfhwt_row_writer.sv
// Self-checking bench for mfhwt_row_writer: pixel-count reference model,
// per-FIFO scoreboard and directed stall / reset sequences.
module tb_mfhwt_row_writer;

  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int DW    = 16;
  localparam int BAND  = 4 * IMG_W;
  localparam int FRAME = IMG_W * IMG_H;

  logic          clk = 1'b0;
  logic          rst, start, valid;
  logic [DW-1:0] data;
  logic [3:0]    full;
  logic          oReady, oBandDone, oFrameDone, oBusy;
  logic [3:0]    oWrreq;
  logic [DW-1:0] oData;

  mfhwt_row_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) dut (
    .iClk(clk), .iRst(rst), .iStart(start), .iValid(valid),
    .iData(data), .oReady(oReady), .iFull(full), .oWrreq(oWrreq),
    .oData(oData), .oBandDone(oBandDone), .oFrameDone(oFrameDone),
    .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 writing, 2 frame-done cycle; p = pixels accepted.
  int   mode, p;
  bit   e_band, e_frame, held;
  int   n_chk, n_fail, n_band, n_frame, n_acc;
  logic [DW-1:0] exp_q[4][$];
  logic [DW-1:0] got_q[4][$];
  logic [3:0]    wlog[BAND];

  typedef struct {
    int         pix;
    logic [3:0] wr;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t p=%0d)", name, got, exp, $time, p);
    end
  endtask

  task automatic model_reset();
    mode = 0; p = 0; e_band = 0; e_frame = 0; held = 0;
  endtask

  // One clock: check outputs mid-cycle, advance model at the edge, return 1 after it.
  task automatic cyc();
    int k;
    bit acc;
    bit rdy;
    #4;
    k   = (p / IMG_W) % 4;
    rdy = (mode == 1) && !full[k];
    acc = rdy && valid;
    chk("oReady", oReady, rdy);
    chk("oWrreq", oWrreq, acc ? (4'b0001 << k) : 4'b0000);
    if (acc) chk("oData", oData, data);
    chk("oBandDone", oBandDone, e_band);
    chk("oFrameDone", oFrameDone, e_frame);
    chk("oBusy", oBusy, mode != 0);
    chk("onehot", $countones(oWrreq) <= 1, 1);
    chk("wr_vs_full", oWrreq & full, 0);
    if (acc) begin
      exp_q[k].push_back(data);
      if (p < BAND) wlog[p] = oWrreq;
    end
    for (int j = 0; j < 4; j++)
      if (oWrreq[j]) got_q[j].push_back(oData);
    if (oBandDone) n_band++;
    if (oFrameDone) n_frame++;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      e_band = 0; e_frame = 0;
      case (mode)
        0: if (start) begin mode = 1; p = 0; end
        1: if (acc) begin
             p++; n_acc++;
             if (p % BAND == 0) e_band = 1;
             if (p == FRAME) begin mode = 2; e_frame = 1; end
           end
        default: mode = 0;
      endcase
      held = valid && !acc;
    end
    #1;
  endtask

  task automatic cmp_queues(string tag);
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_qsize"}, got_q[k].size(), exp_q[k].size());
      for (int i = 0; i < exp_q[k].size() && i < got_q[k].size(); i++)
        if (got_q[k][i] !== exp_q[k][i])
          chk({tag, "_qdata"}, got_q[k][i], exp_q[k][i]);
      if (got_q[k].size() == exp_q[k].size() && exp_q[k].size() > 0)
        chk({tag, "_qlast"}, got_q[k][$], exp_q[k][$]);
      got_q[k].delete();
      exp_q[k].delete();
    end
  endtask

  task automatic do_reset();
    rst = 1; start = 0;
    cyc();
    rst = 0;
    n_band = 0; n_frame = 0; n_acc = 0;
  endtask

  task automatic new_data();
    data = DW'($urandom & 32'h7FFF);
  endtask

  task automatic run_to(int target, int budget);
    int b;
    b = 0;
    while (p < target && b < budget) begin
      valid = 1; full = 0;
      if (!held) new_data();
      cyc();
      b++;
    end
    chk("run_to_reached", p, target);
  endtask

  initial begin
    int b, cnt, pos;
    n_chk = 0; n_fail = 0;
    rst = 1; start = 0; valid = 0; data = '0; full = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 0;
    n_band = 0; n_frame = 0; n_acc = 0;

    // Reset state: idle, no ready even with valid source and empty FIFOs.
    cyc();
    valid = 1;
    cyc();
    start = 0; valid = 0;

    // Tests 1+2: full frame no stalls; iStart pulsed in DONE ignored.
    start = 1;
    cyc();
    start = 0;
    b = 0;
    while (!(mode == 0) && b < FRAME + 100) begin
      valid = 1; full = 0;
      start = (mode == 2);
      new_data();
      cyc();
      b++;
    end
    start = 0;
    chk("frame_terminated", mode, 0);
    valid = 1;
    repeat (3) cyc();
    valid = 0;
    chk("band_count", n_band, FRAME / BAND);
    chk("frame_count", n_frame, 1);
    chk("accept_count", n_acc, FRAME);
    chk("idle_ready", oReady, 0);
    chk("idle_busy", oBusy, 0);
    cmp_queues("t2");

    tbl[0] = '{0, 4'b0001};   tbl[1] = '{80, 4'b0001};
    tbl[2] = '{159, 4'b0001}; tbl[3] = '{160, 4'b0010};
    tbl[4] = '{319, 4'b0010}; tbl[5] = '{320, 4'b0100};
    tbl[6] = '{479, 4'b0100}; tbl[7] = '{480, 4'b1000};
    tbl[8] = '{600, 4'b1000}; tbl[9] = '{639, 4'b1000};
    for (int i = 0; i < 10; i++)
      chk($sformatf("stripe_px%0d", tbl[i].pix), wlog[tbl[i].pix], tbl[i].wr);

    // Test 3: iFull[1] stall mid-row 1 with held data; iFull[0] ignored in row 1.
    do_reset();
    start = 1; cyc(); start = 0;
    run_to(IMG_W + 40, 400);
    valid = 1; full = 4'b0011; data = 16'hBEEF;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("stall_ready", oReady, 0);
    end
    chk("stall_col_frozen", p, IMG_W + 40);
    full = 4'b0001;
    cyc();
    for (int i = 0; i < 20; i++) begin
      new_data();
      cyc();
    end
    full = 0;
    cnt = 0; pos = -1;
    for (int i = 0; i < got_q[1].size(); i++)
      if (got_q[1][i] == 16'hBEEF) begin cnt++; pos = i; end
    chk("held_written_once", cnt, 1);
    chk("held_position", pos, 40);
    cmp_queues("t3");

    // Test 4: random valid and random full flags against the scoreboard.
    do_reset();
    start = 1; cyc(); start = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!held) begin
        valid = $urandom_range(0, 1);
        new_data();
      end
      full = 4'($urandom & $urandom);
      cyc();
    end
    full = 0; valid = 0;
    chk("rand_progress", p > 4 * IMG_W, 1);
    chk("rand_bands", n_band, p / BAND);
    cmp_queues("t4");

    // Test 5: abort at row 5 col 37; iStart during WRITE ignored; restart at slot 0.
    do_reset();
    start = 1; cyc(); start = 0;
    run_to(5 * IMG_W + 30, 1000);
    start = 1; valid = 1;
    repeat (3) begin new_data(); cyc(); end
    start = 0;
    run_to(5 * IMG_W + 37, 100);
    valid = 1; new_data();
    rst = 1; cyc(); rst = 0;
    cyc();
    chk("abort_ready", oReady, 0);
    chk("abort_wrreq", oWrreq, 0);
    chk("abort_busy", oBusy, 0);
    cmp_queues("t5a");
    start = 1; valid = 0; cyc(); start = 0;
    valid = 1; new_data();
    #4;
    chk("restart_slot0", oWrreq, 4'b0001);
    #2;
    @(posedge clk); #1;
    p = 1; n_acc = 1;
    exp_q[0].push_back(data);
    got_q[0].push_back(data);
    run_to(IMG_W + 2, 400);
    cmp_queues("t5b");

    // Test 6: next band blocked on FIFO 0 until released.
    do_reset();
    start = 1; cyc(); start = 0;
    run_to(BAND, 800);
    chk("band1", n_band, 0);
    valid = 1; full = 4'b0001;
    for (int i = 0; i < 50; i++) cyc();
    chk("band_stall_hold", p, BAND);
    chk("band1_seen", n_band, 1);
    full = 0;
    run_to(2 * BAND, 800);
    valid = 0;
    cyc();
    chk("band2_seen", n_band, 2);
    cmp_queues("t6");

    do_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
